// File: rtl/io_terminal_port.sv
// Device side of the basic computer's terminal I/O: keyboard FIFO feeding INPR/FGI,
// OUTR/FGO display handshake, registered interrupt request and protocol-error counter.
module io_terminal_port #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IN_DEPTH = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_ready,
    output logic              dsp_valid,
    output logic [DATA_W-1:0] dsp_data,
    input  logic              dsp_ready,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic [DATA_W-1:0] cpu_ac,
    input  logic              ien,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    output logic              fgo,
    output logic              irq,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned AW = $clog2(IN_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = CNT_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } out_state_t;

    logic [DATA_W-1:0] r_mem [IN_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [DATA_W-1:0] r_inpr;
    logic              r_fgi;
    out_state_t        r_state;
    logic              r_fgo;
    logic              r_dsp_valid;
    logic [DATA_W-1:0] r_dsp_data;
    logic              r_irq;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_inp_err;
    logic              w_out_err;
    logic [SW-1:0]     w_err_sum;
    logic [CNT_W-1:0]  w_err_next;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = kbd_valid & ~w_full;
    assign w_pop   = ~r_fgi & ~w_empty;

    assign w_inp_err  = cpu_inp & ~r_fgi;
    assign w_out_err  = cpu_out & (r_state == S_BUSY);
    assign w_err_sum  = SW'(r_err_cnt) + SW'(w_inp_err) + SW'(w_out_err);
    assign w_err_next = w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];

    // Keyboard FIFO storage and write side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(IN_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= kbd_data;
            r_wr_ptr                <= r_wr_ptr + PW'(1);
        end
    end

    // INPR loader: pop only while FGI is low, so a read always leaves a one-cycle gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_inpr   <= '0;
            r_fgi    <= 1'b0;
        end else if (w_pop) begin
            r_inpr   <= r_mem[r_rd_ptr[AW-1:0]];
            r_fgi    <= 1'b1;
            r_rd_ptr <= r_rd_ptr + PW'(1);
        end else if (cpu_inp && r_fgi) begin
            r_fgi <= 1'b0;
        end
    end

    // Output FSM: OUTR/FGO toward the display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fgo       <= 1'b1;
            r_dsp_valid <= 1'b0;
            r_dsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_out) begin
                        r_dsp_data  <= cpu_ac;
                        r_fgo       <= 1'b0;
                        r_dsp_valid <= 1'b1;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dsp_ready) begin
                        r_dsp_valid <= 1'b0;
                        r_fgo       <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Interrupt request and saturating violation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_irq     <= ien & (r_fgi | r_fgo);
            r_err_cnt <= w_err_next;
        end
    end

    assign kbd_ready = ~w_full;
    assign dsp_valid = r_dsp_valid;
    assign dsp_data  = r_dsp_data;
    assign inpr      = r_inpr;
    assign fgi       = r_fgi;
    assign fgo       = r_fgo;
    assign irq       = r_irq;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_io_terminal_port.sv
// Bench for io_terminal_port: directed scenarios plus randomized traffic against a
// queue-based model of the terminal flags, FIFO and error counter.
module tb_io_terminal_port;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IN_DEPTH = 4;
    localparam int unsigned CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              kbd_valid;
    logic [DATA_W-1:0] kbd_data;
    logic              kbd_ready;
    logic              dsp_valid;
    logic [DATA_W-1:0] dsp_data;
    logic              dsp_ready;
    logic              cpu_inp;
    logic              cpu_out;
    logic [DATA_W-1:0] cpu_ac;
    logic              ien;
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              fgo;
    logic              irq;
    logic [CNT_W-1:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_inpr;
    bit         m_fgi;
    bit         m_busy;
    logic [7:0] m_dsp;
    int         m_err;
    bit         m_irq;

    io_terminal_port #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
        .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ac(cpu_ac), .ien(ien),
        .inpr(inpr), .fgi(fgi), .fgo(fgo), .irq(irq), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_inpr = 8'h00;
        m_fgi  = 1'b0;
        m_busy = 1'b0;
        m_dsp  = 8'h00;
        m_err  = 0;
        m_irq  = 1'b0;
    endtask

    task automatic idle_inputs();
        kbd_valid = 1'b0;
        kbd_data  = 8'h00;
        dsp_ready = 1'b0;
        cpu_inp   = 1'b0;
        cpu_out   = 1'b0;
        cpu_ac    = 8'h00;
    endtask

    // Advance one clock edge; model follows the terminal rules on pre-edge values.
    task automatic step();
        logic [7:0] nq[$];
        logic [7:0] n_inpr;
        bit n_fgi, n_busy, n_irq;
        logic [7:0] n_dsp;
        int n_err;
        nq = q; n_inpr = m_inpr; n_fgi = m_fgi; n_busy = m_busy; n_dsp = m_dsp; n_err = m_err;
        n_irq = ien && (m_fgi || !m_busy);
        if (!m_fgi && q.size() > 0) begin
            n_inpr = nq.pop_front();
            n_fgi  = 1'b1;
        end else if (cpu_inp && m_fgi) begin
            n_fgi = 1'b0;
        end
        if (cpu_inp && !m_fgi) n_err++;
        if (kbd_valid && q.size() < IN_DEPTH) nq.push_back(kbd_data);
        if (!m_busy) begin
            if (cpu_out) begin
                n_busy = 1'b1;
                n_dsp  = cpu_ac;
            end
        end else begin
            if (cpu_out) n_err++;
            if (dsp_ready) n_busy = 1'b0;
        end
        if (n_err > 255) n_err = 255;
        @(posedge clk);
        #1;
        q = nq; m_inpr = n_inpr; m_fgi = n_fgi; m_busy = n_busy; m_dsp = n_dsp;
        m_err = n_err; m_irq = n_irq;
    endtask

    task automatic test_reset();
        idle_inputs();
        ien   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (fgo !== 1'b1) begin n_errors++; $display("FAIL reset_fgo: got %0b exp 1", fgo); end
        n_checks++; if (fgi !== 1'b0) begin n_errors++; $display("FAIL reset_fgi: got %0b exp 0", fgi); end
        n_checks++; if (kbd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_kbd_ready: got %0b exp 1", kbd_ready); end
        n_checks++; if (dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin n_errors++; $display("FAIL reset_dsp: got valid=%0b data=%h exp 0/00", dsp_valid, dsp_data); end
        n_checks++; if (inpr !== 8'h00 || err_cnt !== 8'h00 || irq !== 1'b0) begin n_errors++; $display("FAIL reset_misc: got inpr=%h err=%h irq=%0b exp 00/00/0", inpr, err_cnt, irq); end
        ien = 1'b1;
        step();
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL reset_irq: got %0b exp 1", irq); end
    endtask

    task automatic test_single_byte();
        kbd_valid = 1'b1; kbd_data = 8'h41;
        step();
        kbd_valid = 1'b0;
        n_checks++; if (fgi !== 1'b0) begin n_errors++; $display("FAIL single_fgi_early: got %0b exp 0", fgi); end
        step();
        n_checks++; if (fgi !== 1'b1) begin n_errors++; $display("FAIL single_fgi: got %0b exp 1", fgi); end
        n_checks++; if (inpr !== 8'h41) begin n_errors++; $display("FAIL single_inpr: got %h exp 41", inpr); end
        cpu_inp = 1'b1;
        step();
        cpu_inp = 1'b0;
        n_checks++; if (fgi !== 1'b0) begin n_errors++; $display("FAIL single_fgi_clear: got %0b exp 0", fgi); end
        n_checks++; if (err_cnt !== 8'h00) begin n_errors++; $display("FAIL single_err: got %h exp 00", err_cnt); end
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int i = 0; i < 5; i++) begin
            kbd_valid = 1'b1; kbd_data = 8'(8'h31 + i);
            n_checks++; if (kbd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_before_%0d: got %0b exp 1", i, kbd_ready); end
            step();
        end
        kbd_valid = 1'b0;
        n_checks++; if (kbd_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_full: got %0b exp 0", kbd_ready); end
        for (int k = 0; k < 5; k++) begin
            budget = 4;
            while (fgi !== 1'b1 && budget > 0) begin step(); budget--; end
            n_checks++; if (fgi !== 1'b1) begin n_errors++; $display("FAIL b2b_wait_%0d: got fgi=%0b exp 1", k, fgi); end
            n_checks++; if (inpr !== 8'(8'h31 + k)) begin n_errors++; $display("FAIL b2b_order_%0d: got %h exp %h", k, inpr, 8'(8'h31 + k)); end
            cpu_inp = 1'b1;
            step();
            cpu_inp = 1'b0;
            n_checks++; if (fgi !== 1'b0) begin n_errors++; $display("FAIL b2b_gap_%0d: got fgi=%0b exp 0", k, fgi); end
        end
        n_checks++; if (err_cnt !== 8'h00 || kbd_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_end: got err=%h ready=%0b exp 00/1", err_cnt, kbd_ready); end
    endtask

    task automatic test_output();
        cpu_out = 1'b1; cpu_ac = 8'h5A; dsp_ready = 1'b0;
        step();
        cpu_out = 1'b0; cpu_ac = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h5A || fgo !== 1'b0) begin n_errors++; $display("FAIL out_busy_%0d: got valid=%0b data=%h fgo=%0b exp 1/5a/0", c, dsp_valid, dsp_data, fgo); end
            step();
        end
        dsp_ready = 1'b1;
        step();
        dsp_ready = 1'b0;
        n_checks++; if (fgo !== 1'b1 || dsp_valid !== 1'b0) begin n_errors++; $display("FAIL out_done: got fgo=%0b valid=%0b exp 1/0", fgo, dsp_valid); end
    endtask

    task automatic test_violations();
        int e0;
        cpu_out = 1'b1; cpu_ac = 8'h77;
        step();
        cpu_ac = 8'h99; cpu_inp = 1'b1;
        e0 = int'(err_cnt);
        step();
        n_checks++; if (int'(err_cnt) !== e0 + 2) begin n_errors++; $display("FAIL viol_double: got %0d exp %0d", err_cnt, e0 + 2); end
        n_checks++; if (dsp_data !== 8'h77) begin n_errors++; $display("FAIL viol_outr: got %h exp 77", dsp_data); end
        for (int i = 0; i < 150; i++) begin
            cpu_ac = 8'($urandom);
            step();
        end
        n_checks++; if (err_cnt !== 8'hFF) begin n_errors++; $display("FAIL viol_saturate: got %h exp ff", err_cnt); end
        n_checks++; if (dsp_data !== 8'h77) begin n_errors++; $display("FAIL viol_outr_hold: got %h exp 77", dsp_data); end
        cpu_out = 1'b0; cpu_inp = 1'b0; dsp_ready = 1'b1;
        step();
        dsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        cpu_out = 1'b1; cpu_ac = 8'h12;
        step();
        cpu_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            kbd_valid = 1'b1; kbd_data = 8'(8'hC0 + i);
            step();
        end
        kbd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (fgo !== 1'b1 || dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin n_errors++; $display("FAIL rstmid_out: got fgo=%0b valid=%0b data=%h exp 1/0/00", fgo, dsp_valid, dsp_data); end
        n_checks++; if (fgi !== 1'b0 || inpr !== 8'h00 || kbd_ready !== 1'b1 || err_cnt !== 8'h00) begin n_errors++; $display("FAIL rstmid_in: got fgi=%0b inpr=%h ready=%0b err=%h exp 0/00/1/00", fgi, inpr, kbd_ready, err_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        n_checks++; if (fgi !== 1'b0) begin n_errors++; $display("FAIL rstmid_empty: got fgi=%0b exp 0", fgi); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            kbd_valid = ($urandom_range(0, 99) < 40);
            kbd_data  = 8'($urandom);
            cpu_inp   = ($urandom_range(0, 99) < 25);
            cpu_out   = ($urandom_range(0, 99) < 20);
            cpu_ac    = 8'($urandom);
            dsp_ready = ($urandom_range(0, 99) < 35);
            ien       = ($urandom_range(0, 99) < 70);
            step();
            n_checks++; if (kbd_ready !== (q.size() < IN_DEPTH)) begin n_errors++; $display("FAIL rnd_ready@%0d: got %0b exp %0b", c, kbd_ready, q.size() < IN_DEPTH); end
            n_checks++; if (fgi !== m_fgi || inpr !== m_inpr) begin n_errors++; $display("FAIL rnd_input@%0d: got fgi=%0b inpr=%h exp %0b/%h", c, fgi, inpr, m_fgi, m_inpr); end
            n_checks++; if (fgo !== !m_busy || dsp_valid !== m_busy || dsp_data !== m_dsp) begin n_errors++; $display("FAIL rnd_output@%0d: got fgo=%0b valid=%0b data=%h exp %0b/%0b/%h", c, fgo, dsp_valid, dsp_data, !m_busy, m_busy, m_dsp); end
            n_checks++; if (irq !== m_irq) begin n_errors++; $display("FAIL rnd_irq@%0d: got %0b exp %0b", c, irq, m_irq); end
            n_checks++; if (int'(err_cnt) !== m_err) begin n_errors++; $display("FAIL rnd_err@%0d: got %0d exp %0d", c, err_cnt, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_output();
        test_violations();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
